shift_acc: RTL
==============

Name: shift_acc

Overview:
- Bit-serial shift-and-accumulate stage sitting directly downstream of the `add` adder tree in the DCIM macro.
- Each cycle the adder tree delivers one partial sum per activation bit-plane, MSB plane first.
- This block combines ACT_BITS consecutive planes into one full-precision MAC result, i.e. acc = (acc << 1) + plane.
- Signed mode applies two's-complement weighting to the MSB plane, then presents the result with a valid/ready handshake.

Parameters:
- IN_W, 13, width of the adder-tree sum (matches `add` output for width=12).
- ACT_BITS, 8, number of activation bit-planes per frame (≥2).
- OUT_W, IN_W+ACT_BITS, result width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- sus  in  1  0 = unsigned, 1 = signed. Sampled on the first beat of each frame.
- in_valid  in  1  in_data carries a valid plane sum.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  IN_W  plane partial sum. Two's-complement when sus=1, unsigned when sus=0.
- out_valid  out  1  out_data holds a completed frame result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_W  accumulated result. Signed when the frame's sus=1.
- frame_active  out  1  high while 1..ACT_BITS-1 beats of the current frame have been accepted.

Behaviour:
- A beat is accepted when in_valid && in_ready.
- A frame is exactly ACT_BITS accepted beats; idle cycles between beats are allowed.
- Reset values: out_valid=0, out_data=0, frame_active=0, plane counter cnt=0, acc=0, sus_q=0. in_ready=1 after reset.
- Extension: ext(x) = sign-extend in_data to OUT_W if sus_q (or sus on the first beat), else zero-extend.
- First beat (cnt==0):
  - sus_q <= sus.
  - acc <= sus ? -ext(in_data) : ext(in_data).
  - Negation applies only to the MSB plane.
- Later beats: acc <= (acc << 1) + ext(in_data), arithmetic in OUT_W bits.
- cnt increments per accepted beat. On the beat with cnt==ACT_BITS-1:
  - out_data <= final sum (acc shifted plus that plane).
  - out_valid <= 1.
  - cnt <= 0.
- Latency: out_valid rises the cycle after the last beat is accepted.
- No overflow is possible:
  - Unsigned: max (2^IN_W-1)(2^ACT_BITS-1) < 2^OUT_W.
  - Signed: |result| ≤ 2^(OUT_W-2).
- Output hold: out_valid and out_data remain stable while out_valid && !out_ready. out_valid clears on handshake unless a new result loads in the same cycle.
- in_ready = !(cnt==ACT_BITS-1 && out_valid && !out_ready). The next frame may accumulate planes 0..ACT_BITS-2 while the previous result awaits; only its final beat stalls.
- Simultaneous out handshake and final-beat accept: the new result overwrites and out_valid stays 1.
- sus changing mid-frame is ignored; sus_q governs the whole frame.
- rst mid-frame: the partial frame is discarded, outputs return to reset values, and the next accepted beat is treated as plane 0.
- frame_active = (cnt != 0).

Decomposition:
- Package `dcim_pkg`:
  - default IN_W/ACT_BITS constants.
  - mode encoding constants SUS_UNSIGNED=0, SUS_SIGNED=1.
  - function for OUT_W derivation.
- Single module; no sub-module needed. An optional `add` instance for the shift+plane addition is permitted but not required.

Test Plan:
(Bench overrides ACT_BITS=4, IN_W=13, so OUT_W=17.)
1. sus=0, planes 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, out_data=26.
2. sus=1, planes 1,2,3,4 -> out_data=10 (−8+8+6+4). Then planes −5,0,0,0 -> out_data=40. Then planes 3,0,0,1 -> out_data=−23.
3. Extremes:
   - sus=0, four planes of 8191 -> 122865.
   - sus=1, planes −4096,0,0,0 -> 32768.
   - sus=1, four planes of −4096 -> 4096.
4. Backpressure: out_ready=0 after frame A=26; stream frame B (1,1,1,1).
   - in_ready drops only at B's 4th beat, with out_data held at 26.
   - Raise out_ready -> B's final beat is accepted that cycle and out_data=15 the next cycle.
5. Gapped input and mid-frame sus toggle: sus=1 at beat 0, sus=0 from beat 1, in_valid low 2 cycles between beats, planes 1,0,0,0 -> out_data=−8.
6. Reset mid-frame: after 2 accepted beats assert rst 1 cycle -> out_valid=0, frame_active=0. A following frame 0,0,0,7 (sus=0) -> out_data=7.

Source files
------------

// File: rtl/dcim_pkg.sv
// dcim_pkg: shared constants and width helper for the DCIM datapath
package dcim_pkg;
  localparam int DEF_IN_W = 13;
  localparam int DEF_ACT_BITS = 8;
  localparam logic SUS_UNSIGNED = 1'b0;
  localparam logic SUS_SIGNED = 1'b1;
  function automatic int out_w(input int in_w, input int act_bits);
    return in_w + act_bits;
  endfunction
endpackage

// File: rtl/shift_acc.sv
// shift_acc: bit-serial shift-and-accumulate of MSB-first plane sums into one MAC result
module shift_acc
  import dcim_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int ACT_BITS = DEF_ACT_BITS,
  localparam int OUT_W = out_w(IN_W, ACT_BITS),
  localparam int CW = $clog2(ACT_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sus,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             frame_active
);
  logic [CW-1:0] cnt;
  logic [OUT_W-1:0] acc, ext, nxt;
  logic sus_q, first, last, signed_mode, fire;
  // plane extension uses the live mode on plane 0 and the latched mode afterwards; MSB plane is negated in signed mode
  always_comb begin
    first = cnt == '0;
    last = cnt == CW'(ACT_BITS - 1);
    signed_mode = first ? sus == SUS_SIGNED : sus_q;
    ext = signed_mode ? {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data} : {{(OUT_W-IN_W){1'b0}}, in_data};
    nxt = first ? (signed_mode ? -ext : ext) : (acc << 1) + ext;
    in_ready = !(last && out_valid && !out_ready);
    fire = in_valid && in_ready;
    frame_active = !first;
  end
  // accumulate accepted planes and publish the result on the final plane, holding it until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      sus_q <= SUS_UNSIGNED;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (fire) begin
        acc <= nxt;
        cnt <= last ? '0 : cnt + 1'b1;
        if (first) sus_q <= sus;
        if (last) begin
          out_data <= nxt;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule
